key_sw_debounce: RTL and testbench

Front-end conditioning block for the board's raw user inputs: 4 push keys (active-low, released = 1) and 4 slide switches. It synchronises every input to `clk`, debounces each channel independently, and emits clean levels plus single-cycle press, release and long-press events. It sits between the `key_input`/`sw_input` pins and the LED and segment-display logic in `top`, and consumes exactly the stimulus the top-level bench drives.

---
 rtl/key_sw_debounce.sv | 145 ++++++++++++++
 tb/tb_key_sw_debounce.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/key_sw_debounce.sv
// Input conditioning for 4 active-low push keys and 4 slide switches:
// 2-flop synchronisers, per-channel debounce, and per-key press/release/long-press events.
module key_sw_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 240000,
  parameter int unsigned LONG_CYCLES     = 12000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] key_input,
  input  logic [3:0] sw_input,
  output logic [3:0] key_level,
  output logic [3:0] key_press,
  output logic [3:0] key_release,
  output logic [3:0] key_long,
  output logic [3:0] sw_level
);

  localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES);
  localparam int unsigned HW = $clog2(LONG_CYCLES);
  localparam logic [DW-1:0] DEB_MAX  = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] LONG_MAX = HW'(LONG_CYCLES - 1);
  // Channel order is {sw[3:0], key[3:0]}; key bits are active-low on the pins.
  localparam logic [7:0] KEY_INV = 8'h0F;

  typedef enum logic [1:0] {
    ST_RELEASED,
    ST_PRESSED,
    ST_LONG
  } key_state_e;

  logic [7:0]    sync1_q, sync1_d;
  logic [7:0]    sync2_q, sync2_d;
  logic [7:0]    stab_q, stab_d;
  logic [DW-1:0] cnt_q [8];
  logic [DW-1:0] cnt_d [8];
  logic [7:0]    accept;
  logic [7:0]    samp_act;

  key_state_e    state_q [4];
  key_state_e    state_d [4];
  logic [HW-1:0] hold_q [4];
  logic [HW-1:0] hold_d [4];
  logic [3:0]    press_q, press_d;
  logic [3:0]    release_q, release_d;
  logic [3:0]    long_q, long_d;

  // NOTE: every signal gets its default before any branch, so no path leaves it unassigned (no latch).
  always_comb begin
    sync1_d  = {sw_input, key_input};
    sync2_d  = sync1_q;
    stab_d   = stab_q;
    accept   = '0;
    samp_act = sync2_q ^ KEY_INV;
    for (int c = 0; c < 8; c++) begin
      cnt_d[c] = cnt_q[c];
      if (samp_act[c] == stab_q[c]) begin
        cnt_d[c] = '0;
      end else if (cnt_q[c] == DEB_MAX) begin
        stab_d[c] = samp_act[c];
        cnt_d[c]  = '0;
        accept[c] = 1'b1;
      end else begin
        cnt_d[c] = cnt_q[c] + 1'b1;
      end
    end

    press_d   = '0;
    release_d = '0;
    long_d    = '0;
    for (int k = 0; k < 4; k++) begin
      state_d[k] = state_q[k];
      hold_d[k]  = hold_q[k];
      case (state_q[k])
        ST_RELEASED: begin
          hold_d[k] = '0;
          if (accept[k] && stab_d[k]) begin
            state_d[k] = ST_PRESSED;
            press_d[k] = 1'b1;
          end
        end
        ST_PRESSED: begin
          // Release is tested first so it beats a long-press expiring on the same edge.
          if (accept[k] && !stab_d[k]) begin
            state_d[k]   = ST_RELEASED;
            release_d[k] = 1'b1;
            hold_d[k]    = '0;
          end else if (hold_q[k] == LONG_MAX) begin
            state_d[k] = ST_LONG;
            long_d[k]  = 1'b1;
          end else begin
            hold_d[k] = hold_q[k] + 1'b1;
          end
        end
        ST_LONG: begin
          if (accept[k] && !stab_d[k]) begin
            state_d[k]   = ST_RELEASED;
            release_d[k] = 1'b1;
            hold_d[k]    = '0;
          end
        end
        default: begin
          state_d[k] = ST_RELEASED;
          hold_d[k]  = '0;
        end
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q   <= KEY_INV;
      sync2_q   <= KEY_INV;
      stab_q    <= '0;
      press_q   <= '0;
      release_q <= '0;
      long_q    <= '0;
      // NOTE: the counter arrays are real state the debounce depends on, so they are reset too.
      for (int c = 0; c < 8; c++) cnt_q[c] <= '0;
      for (int k = 0; k < 4; k++) begin
        state_q[k] <= ST_RELEASED;
        hold_q[k]  <= '0;
      end
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      stab_q    <= stab_d;
      press_q   <= press_d;
      release_q <= release_d;
      long_q    <= long_d;
      for (int c = 0; c < 8; c++) cnt_q[c] <= cnt_d[c];
      for (int k = 0; k < 4; k++) begin
        state_q[k] <= state_d[k];
        hold_q[k]  <= hold_d[k];
      end
    end
  end

  assign key_level   = stab_q[3:0];
  assign sw_level    = stab_q[7:4];
  assign key_press   = press_q;
  assign key_release = release_q;
  assign key_long    = long_q;

endmodule

// File: tb/tb_key_sw_debounce.sv
// Self-checking bench for key_sw_debounce: directed scenarios plus randomized toggling,
// every cycle compared against a run-length / timestamp reference model.
module tb_key_sw_debounce;
  localparam int D = 8;
  localparam int L = 32;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] key_input;
  logic [3:0] sw_input;
  logic [3:0] key_level, key_press, key_release, key_long, sw_level;

  always #5 clk = ~clk;

  key_sw_debounce #(.DEBOUNCE_CYCLES(D), .LONG_CYCLES(L)) dut (
    .clk        (clk),
    .rst        (rst),
    .key_input  (key_input),
    .sw_input   (sw_input),
    .key_level  (key_level),
    .key_press  (key_press),
    .key_release(key_release),
    .key_long   (key_long),
    .sw_level   (sw_level)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  // Reference model state, all in "active" polarity (1 = pressed / switch on).
  bit         m_s1 [8];
  bit         m_s2 [8];
  bit         m_stab [8];
  int         m_run [8];
  bit         m_held [4];
  bit         m_long_done [4];
  int         m_press_t [4];
  logic [3:0] e_level, e_press, e_rel, e_long, e_sw;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Expected outputs after the coming edge, given the inputs presented to it.
  // A channel is accepted once its synchronised (2-edge delayed) sample has differed
  // from the accepted value on D consecutive edges; long fires L edges after the press edge.
  task automatic model_step();
    int  edge_n;
    bit  a, samp, ev;
    edge_n = cyc + 1;
    if (rst) begin
      for (int c = 0; c < 8; c++) begin
        m_s1[c] = 0; m_s2[c] = 0; m_stab[c] = 0; m_run[c] = 0;
      end
      for (int k = 0; k < 4; k++) begin
        m_held[k] = 0; m_long_done[k] = 0; m_press_t[k] = 0;
      end
      e_press = '0; e_rel = '0; e_long = '0;
    end else begin
      e_press = '0; e_rel = '0; e_long = '0;
      for (int c = 0; c < 8; c++) begin
        if (c < 4) a = !key_input[c];
        else       a = sw_input[c - 4];
        samp = m_s2[c];
        ev   = 0;
        if (samp != m_stab[c]) begin
          m_run[c]++;
          if (m_run[c] == D) begin
            m_stab[c] = samp;
            m_run[c]  = 0;
            ev        = 1;
          end
        end else begin
          m_run[c] = 0;
        end
        m_s2[c] = m_s1[c];
        m_s1[c] = a;
        if (c < 4) begin
          if (ev && m_stab[c]) begin
            e_press[c] = 1'b1;
            m_held[c] = 1; m_long_done[c] = 0; m_press_t[c] = edge_n;
          end else if (ev && !m_stab[c]) begin
            e_rel[c] = 1'b1;
            m_held[c] = 0;
          end else if (m_held[c] && !m_long_done[c] && (edge_n - m_press_t[c] == L)) begin
            e_long[c] = 1'b1;
            m_long_done[c] = 1;
          end
        end
      end
    end
    for (int c = 0; c < 4; c++) begin
      e_level[c] = m_stab[c];
      e_sw[c]    = m_stab[c + 4];
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    cyc++;
    check($sformatf("outputs_cycle%0d", cyc),
          {12'b0, key_level, key_press, key_release, key_long, sw_level},
          {12'b0, e_level, e_press, e_rel, e_long, e_sw});
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1);
  end

  initial begin
    int k, found, cnt, p, long_cyc, long_cnt, rel_cyc, rel_cnt, r, div;
    rst       = 1'b1;
    key_input = 4'b1111;
    sw_input  = 4'b0000;

    // Reset, then 50 idle cycles with no pulses.
    repeat (3) tick();
    rst = 1'b0;
    cnt = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if ((key_level | key_press | key_release | key_long | sw_level) != 4'b0) cnt++;
    end
    check("idle_quiet", cnt, 0);

    // Key0 press: level at edge k+9, single press pulse.
    key_input = 4'b1110;
    k = cyc + 1; found = -1; cnt = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (found < 0 && key_level[0]) found = cyc;
      if (key_press[0]) cnt++;
    end
    check("key0_latency", found - k, 9);
    check("key0_press_once", cnt, 1);
    check("key0_level", {28'b0, key_level}, 32'h1);

    // Key1 glitch of 5 cycles.
    key_input = 4'b1100;
    repeat (5) tick();
    key_input = 4'b1110;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (key_level[1] | key_press[1] | key_release[1]) cnt++;
    end
    check("key1_glitch", cnt, 0);

    // Key2 long press, held 60 cycles after acceptance.
    key_input = 4'b1010;
    p = -1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (key_press[2]) begin p = cyc; break; end
    end
    check("key2_press_seen", {31'b0, p >= 0}, 32'h1);
    long_cyc = -1; long_cnt = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (key_long[2]) begin long_cnt++; long_cyc = cyc; end
    end
    key_input = 4'b1110;
    r = cyc + 1; rel_cyc = -1; rel_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (key_long[2]) long_cnt++;
      if (key_release[2]) begin rel_cnt++; rel_cyc = cyc; end
    end
    check("key2_long_once", long_cnt, 1);
    check("key2_long_delay", long_cyc - p, L);
    check("key2_release_once", rel_cnt, 1);
    check("key2_release_latency", rel_cyc - r, 9);

    // Switch 3 on, then a 3-cycle glitch off.
    sw_input = 4'b1000;
    k = cyc + 1; found = -1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (found < 0 && sw_level[3]) found = cyc;
    end
    check("sw3_latency", found - k, 9);
    sw_input = 4'b0000;
    repeat (3) tick();
    sw_input = 4'b1000;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (sw_level != 4'b1000) cnt++;
    end
    check("sw3_glitch", cnt, 0);

    // Release key0, press all keys, then reset while held.
    key_input = 4'b1111;
    repeat (15) tick();
    key_input = 4'b0000;
    repeat (12) tick();
    check("all_pressed", {28'b0, key_level}, 32'hF);
    rst = 1'b1;
    tick();
    r = cyc;
    check("rst_clears", {12'b0, key_level, key_press, key_release, key_long, sw_level}, 32'h0);
    rst = 1'b0;
    found = -1;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (found < 0 && key_press == 4'b1111) found = cyc;
    end
    // Reset edge, then 9 edges after the first edge with rst low.
    check("repress_after_rst", found - r, 10);

    // Randomized toggling with occasional resets.
    for (int s = 0; s < 6; s++) begin
      case ($urandom_range(0, 3))
        0:       div = 4;
        1:       div = 10;
        2:       div = 30;
        default: div = 80;
      endcase
      for (int i = 0; i < 400; i++) begin
        for (int b = 0; b < 4; b++) begin
          if ($urandom_range(0, div - 1) == 0) key_input[b] = ~key_input[b];
          if ($urandom_range(0, div - 1) == 0) sw_input[b]  = ~sw_input[b];
        end
        rst = ($urandom_range(0, 599) == 0);
        tick();
      end
    end
    rst = 1'b0;
    repeat (5) tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
